// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the sized data memory and its helpers.
//   - size encodings for byte/half/word accesses
//   - FSM state type for the request/response sequencer
//   - size_to_bytes: access size -> byte count (0 for the illegal encoding)
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: combinational load extension.
//   raw_data  in  32  big-endian bytes starting at the load address (byte 0 in [31:24])
//   size      in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   zero_ext  in  1   1 = zero-extend, 0 = sign-extend
//   rdata     out 32  right-justified, extended load result (0 for illegal size)
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] rdata
);

    logic sign_byte;
    logic sign_half;

    always_comb begin
        rdata     = '0;
        sign_byte = ~zero_ext & raw_data[31];
        sign_half = ~zero_ext & raw_data[31];
        case (size)
            SZ_BYTE: rdata = {{24{sign_byte}}, raw_data[31:24]};
            SZ_HALF: rdata = {{16{sign_half}}, raw_data[31:16]};
            SZ_WORD: rdata = raw_data;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressable, big-endian data memory with byte/half/word
// accesses, alignment/range checking and LATENCY wait cycles per access.
// One transaction outstanding; valid/ready on both request and response.
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  request can be accepted (IDLE)
//   req_write     in   1 = store, 0 = load
//   req_size      in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1 = zero-extend loads, 0 = sign-extend
//   req_addr      in   byte address (ADDR_W bits)
//   req_wdata     in   store data, right-justified
//   resp_valid    out  response present (RESP)
//   resp_ready    in   consumer takes the response
//   resp_rdata    out  load result; 0 for stores and errors
//   resp_error    out  misaligned, out-of-range or illegal size
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;

    logic               lat_write;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_wdata;

    logic [7:0]         mem [DEPTH_BYTES];

    logic               accept;
    logic               commit;
    logic               req_err;
    logic               misalign;
    logic [2:0]         req_nbytes;
    logic [ADDR_W:0]    req_last;

    logic               c_write;
    logic [1:0]         c_size;
    logic               c_unsigned;
    logic [IDX_W-1:0]   c_idx;
    logic [31:0]        c_wdata;
    logic [2:0]         c_nbytes;
    logic [31:0]        raw;
    logic [31:0]        wfield;
    logic [31:0]        load_data;

    // Request checks use the full address with one extra bit so the
    // end-of-access address cannot wrap back into range.
    always_comb begin
        req_nbytes = size_to_bytes(req_size);
        req_last   = {1'b0, req_addr} + (ADDR_W+1)'(req_nbytes) - (ADDR_W+1)'(1);
        misalign   = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_err    = (req_size == 2'b11) || misalign ||
                     (req_last >= (ADDR_W+1)'(DEPTH_BYTES));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (LATENCY == 0) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Commit operands come straight from the request when committing at the
    // accepting edge (LATENCY == 0), otherwise from the latched request.
    always_comb begin
        c_write    = (state == IDLE) ? req_write                : lat_write;
        c_size     = (state == IDLE) ? req_size                 : lat_size;
        c_unsigned = (state == IDLE) ? req_unsigned             : lat_unsigned;
        c_idx      = (state == IDLE) ? req_addr[IDX_W-1:0]      : lat_idx;
        c_wdata    = (state == IDLE) ? req_wdata                : lat_wdata;
        c_nbytes   = size_to_bytes(c_size);

        raw = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            raw[8*(3-k) +: 8] = mem[c_idx + IDX_W'(k)];
        end

        // Left-justify the store field so byte k of the access is always
        // wfield[31-8k -: 8], i.e. the MSB of the field lands at the address.
        case (c_size)
            SZ_BYTE: wfield = {c_wdata[7:0], 24'h0};
            SZ_HALF: wfield = {c_wdata[15:0], 16'h0};
            default: wfield = c_wdata;
        endcase
    end

    dmem_load_ext u_load_ext (
        .raw_data (raw),
        .size     (c_size),
        .zero_ext (c_unsigned),
        .rdata    (load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'(i + 1);
            end
        end else begin
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_idx      <= req_addr[IDX_W-1:0];
                lat_wdata    <= req_wdata;
                if (req_err) begin
                    resp_error <= 1'b1;
                    resp_rdata <= '0;
                end else if (LATENCY != 0) begin
                    cnt <= CNT_W'(LATENCY - 1);
                end
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (commit) begin
                resp_error <= 1'b0;
                if (c_write) begin
                    resp_rdata <= '0;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (k < 32'(c_nbytes)) begin
                            mem[c_idx + IDX_W'(k)] <= wfield[8*(3-k) +: 8];
                        end
                    end
                end else begin
                    resp_rdata <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: randomized and directed checks of dmem_sized against a
// byte-array reference model. Instance dut uses LATENCY=2, dut_z LATENCY=0.
module tb_dmem_sized;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
    logic [1:0]  z_req_size;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_ready, z_resp_error;
    logic [31:0] z_resp_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  mref [2][DEPTH];

    always #5 clock = ~clock;

    dmem_sized #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    dmem_sized #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(0)) dut_z (
        .clock(clock), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_size(z_req_size), .req_unsigned(z_req_unsigned), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_error(z_resp_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < int'(DEPTH); i++)
                mref[w][i] = 8'(i + 1);
    endtask

    // Reference: legality from plain arithmetic, big-endian byte-by-byte access.
    task automatic model_txn(input int which, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             output logic exp_err, output logic [31:0] exp_rd);
        longint unsigned a, n, v;
        a = 64'(addr);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (n == 0) || ((a % n) != 0) || (a + n > 64'(DEPTH));
        exp_rd  = '0;
        if (!exp_err) begin
            if (wr) begin
                for (longint unsigned k = 0; k < n; k++)
                    mref[which][a + k] = 8'((64'(wd) >> (8 * (n - 1 - k))) & 64'hFF);
            end else begin
                v = 0;
                for (longint unsigned k = 0; k < n; k++)
                    v = (v << 8) | 64'(mref[which][a + k]);
                if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                    v = v | ~((64'd1 << (8 * n)) - 1);
                exp_rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int unsigned hold,
                       input logic has_plan, input logic [31:0] plan, input string tag);
        logic        e;
        logic [31:0] rd;
        int unsigned lat;
        model_txn(0, wr, sz, uns, addr, wd, e, rd);
        @(negedge clock);
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ":latency"}, lat, e ? 32'd1 : 32'(LAT + 1));
        check({tag, ":rdata"}, resp_rdata, rd);
        check({tag, ":error"}, 32'(resp_error), 32'(e));
        if (has_plan) check({tag, ":plan"}, resp_rdata, plan);
        for (int unsigned i = 0; i < hold; i++) begin
            // A competing request during RESP must be ignored.
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
            req_addr = 32'd0; req_wdata = 32'hFFFF_FFFF;
            @(negedge clock);
            check({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ":hold_rdata"}, resp_rdata, rd);
            check({tag, ":hold_error"}, 32'(resp_error), 32'(e));
            check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check({tag, ":done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ":done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        e, wr, uns, prev_store;
        logic [1:0]  sz, prev_sz;
        logic [31:0] addr, wd, rd, prev_addr;

        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_size = 0; z_req_unsigned = 0;
        z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", 32'(resp_error), 32'd0);
        reset = 1'b1;

        txn(0, 2'b10, 0, 32'd0,   32'd0, 0, 1, 32'h0102_0304, "ld_w0");
        txn(0, 2'b00, 0, 32'd254, 32'd0, 0, 1, 32'hFFFF_FFFF, "ld_b254s");
        txn(0, 2'b00, 1, 32'd254, 32'd0, 0, 1, 32'h0000_00FF, "ld_b254u");
        txn(0, 2'b00, 0, 32'd255, 32'd0, 0, 1, 32'h0000_0000, "ld_b255");

        txn(1, 2'b10, 0, 32'd8,  32'hDEAD_BEEF, 0, 1, 32'd0,         "st_w8");
        txn(0, 2'b10, 0, 32'd8,  32'd0,         0, 1, 32'hDEAD_BEEF, "ld_w8");
        txn(0, 2'b00, 0, 32'd9,  32'd0,         0, 1, 32'hFFFF_FFAD, "ld_b9s");
        txn(0, 2'b01, 1, 32'd10, 32'd0,         0, 1, 32'h0000_BEEF, "ld_h10u");
        txn(1, 2'b00, 0, 32'd11, 32'h1234_5677, 0, 1, 32'd0,         "st_b11");
        txn(0, 2'b10, 0, 32'd8,  32'd0,         5, 1, 32'hDEAD_BE77, "ld_w8_bp");

        txn(0, 2'b10, 0, 32'd2,   32'd0,  0, 1, 32'd0, "err_misalign");
        txn(1, 2'b01, 0, 32'd255, 32'hFF, 0, 1, 32'd0, "err_half255");
        txn(0, 2'b10, 0, 32'd256, 32'd0,  0, 1, 32'd0, "err_range");
        txn(0, 2'b11, 0, 32'd0,   32'd0,  0, 1, 32'd0, "err_size");
        txn(0, 2'b00, 0, 32'hFFFF_FFFF, 32'd0, 0, 1, 32'd0, "err_nowrap");
        txn(0, 2'b10, 0, 32'd0,   32'd0,  0, 1, 32'h0102_0304, "ld_w0_after");

        // Reset while a store waits: it must never reach the array.
        @(negedge clock);
        req_valid = 1; req_write = 1; req_size = 2'b10; req_unsigned = 0;
        req_addr = 32'd4; req_wdata = 32'hAAAA_AAAA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 0;
        check("mid_wait_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_error", 32'(resp_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        txn(0, 2'b10, 0, 32'd4, 32'd0, 0, 1, 32'h0506_0708, "ld_w4_after_rst");

        for (int j = 0; j < 40; j++) begin
            wr   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                               : 32'($urandom_range(0, 263));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) addr[0] = 1'b0;
                if (sz == 2'b10) addr[1:0] = 2'b00;
            end
            wd = $urandom;
            txn(wr, sz, uns, addr, wd, $urandom_range(0, 2), 0, 32'd0, "rnd");
        end

        // LATENCY=0 instance: back-to-back, one accept every two cycles.
        z_resp_ready = 1'b1;
        prev_store = 0; prev_sz = 0; prev_addr = 0;
        for (int j = 0; j < 30; j++) begin
            if (j == 0) begin
                wr = 1; sz = 2'b10; uns = 0; addr = 32'd16; wd = 32'hCAFE_F00D;
            end else if ((j % 2 == 1) && prev_store) begin
                wr = 0; sz = prev_sz; uns = 1; addr = prev_addr; wd = $urandom;
            end else begin
                wr   = 1'($urandom_range(0, 1));
                uns  = 1'($urandom_range(0, 1));
                sz   = 2'($urandom_range(0, 2));
                addr = 32'($urandom_range(0, 255));
                if (sz == 2'b01) addr[0] = 1'b0;
                if (sz == 2'b10) addr[1:0] = 2'b00;
                wd = $urandom;
            end
            model_txn(1, wr, sz, uns, addr, wd, e, rd);
            prev_store = wr && !e; prev_sz = sz; prev_addr = addr;
            @(negedge clock);
            check("z_req_ready", 32'(z_req_ready), 32'd1);
            z_req_valid = 1; z_req_write = wr; z_req_size = sz; z_req_unsigned = uns;
            z_req_addr = addr; z_req_wdata = wd;
            @(posedge clock);
            @(negedge clock);
            check("z_resp_valid", 32'(z_resp_valid), 32'd1);
            check("z_busy", 32'(z_req_ready), 32'd0);
            check("z_rdata", z_resp_rdata, rd);
            check("z_error", 32'(z_resp_error), 32'(e));
            if (j == 1) check("z_st_ld_plan", z_resp_rdata, 32'hCAFE_F00D);
            @(posedge clock);
        end
        @(negedge clock);
        z_req_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised, byte-addressable, big-endian data memory for the MEM stage. Next generation of the single-cycle word data memory.
- Adds byte/half/word accesses with signed or unsigned load extension, alignment and range checking, and a configurable wait-state latency.
- Uses a valid/ready request channel and a valid/ready response channel, with one transaction outstanding at a time.

Parameters:
- DEPTH_BYTES, 256, number of bytes in the array; must be a power of 2, minimum 4.
- ADDR_W, 32, request address width.
- LATENCY, 2, wait cycles between request acceptance and the response; 0 is legal.

Ports:
- clock  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- resp_error  out  1  misaligned, out-of-range, or illegal size.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0; wait counter=0.
  - Every byte i is initialised to (i+1) mod 256.
  - Reset mid-transaction discards the transaction; an uncommitted store is never written.
- FSM IDLE:
  - req_ready=1.
  - Accept on a rising edge where req_valid && req_ready; latch write, size, unsigned, addr, wdata.
  - On an error (see below): go to RESP with resp_error=1 and resp_rdata=0, no wait cycles.
  - Else if LATENCY=0: commit at the accepting edge and go to RESP.
  - Else: go to WAIT with counter=LATENCY-1.
- FSM WAIT:
  - req_ready=0.
  - Each edge: if counter==0, commit and go to RESP; else decrement the counter.
- Commit (single edge):
  - Store: write n bytes, n = 1/2/4 by size, big-endian. mem[addr] takes the MSB of the n-byte field; the field is req_wdata[8n-1:0]. resp_rdata=0.
  - Load: resp_rdata = {mem[addr],...,mem[addr+n-1]} in the low 8n bits; upper bits are sign- or zero-extended.
- FSM RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_error are held stable until resp_ready=1 at an edge, then go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Timing:
  - With acceptance at edge k, resp_valid is high in the cycle after edge k+LATENCY.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Error conditions (checked at accept on the full ADDR_W value, no wrap):
  - size==11.
  - addr mod n != 0.
  - addr+n-1 >= DEPTH_BYTES.
  - Error responses never modify memory.
- Inputs are ignored outside the accept edge; changes to req_* during WAIT or RESP have no effect.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/WAIT/RESP.
  - function size_to_bytes.
- Sub-module dmem_load_ext: combinational; takes 32-bit raw big-endian data, size and unsigned; produces the extended resp_rdata. Reused by the future cache.

Test Plan:
- Reset init, LATENCY=2:
  - word load @0 -> 0x01020304, with resp_valid exactly 2 edges after the accept edge.
  - byte load @254 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF.
  - byte load @255 -> 0x00000000.
- Word store 0xDEADBEEF @8, then loads:
  - word load @8 -> 0xDEADBEEF.
  - signed byte load @9 -> 0xFFFFFFAD.
  - unsigned half load @10 -> 0x0000BEEF.
  - byte store 0x1234_5677 @11, then word load @8 -> 0xDEADBE77.
- Errors, each with resp_error=1 in the cycle after the accept edge (no wait) and resp_rdata=0:
  - word load @2.
  - half store @255.
  - word load @256.
  - size=11.
  - Afterwards word load @0 still returns 0x01020304.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_error are stable, req_ready=0, and a new req_valid is not accepted.
- Reset mid-operation: store 0xAAAAAAAA @4 and assert reset=0 during WAIT -> outputs go to reset values immediately; after release, word load @4 -> 0x05060708.
- LATENCY=0 build: back-to-back requests with resp_ready=1 -> accept every 2 cycles; each response is in the cycle after its accept edge; a store followed by a load to the same address returns the stored data.
